// File: rtl/xlib_avalon_dma_rd_ctrl.sv
// xlib_avalon_dma_rd_ctrl
//   Avalon read-master DMA controller. A start pulse launches a transfer of
//   cfg_len words from cfg_addr. The transfer is split into bursts that never
//   cross a MAXB-word boundary, the number of in-flight read beats is capped
//   at MO, and returned words are forwarded one cycle later on o_data/o_val.
//   done pulses with the final o_val beat, or one cycle after a zero-length
//   start.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle transfer request (ignored while busy)
//   cfg_addr/cfg_len  start byte address (word aligned) / length in words
//   busy, done        transfer in progress / one-cycle completion pulse
//   m_rrdy, m_rval    read request handshake
//   m_rlen, m_raddr   burst beats / burst byte address
//   m_rdata, m_rdval  read data return
//   o_data, o_val     forwarded read data stream, no backpressure
module xlib_avalon_dma_rd_ctrl #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int BL   = 4,
  parameter int LW   = 16,
  parameter int MAXB = 8,
  parameter int MO   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] cfg_addr,
  input  logic [LW-1:0] cfg_len,
  output logic          busy,
  output logic          done,
  input  logic          m_rrdy,
  output logic          m_rval,
  output logic [BL-1:0] m_rlen,
  output logic [AW-1:0] m_raddr,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_rdval,
  output logic [DW-1:0] o_data,
  output logic          o_val
);

  localparam int BSH = $clog2(DW / 8);
  localparam int MB  = $clog2(MAXB);
  localparam int OW  = $clog2(MO + 1) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_nx;
  logic [LW-1:0] rem_q, rem_nx, len_q, beat_q;
  logic [BL-1:0] rlen_q;
  logic [OW-1:0] outst_q, outst_sum;
  logic          accept, beat_in, last_beat, go, zero_go;
  logic          busy_c, rval_c, done_q, o_val_q;
  logic [DW-1:0] o_data_q;

  // Words left before the next MAXB-word boundary, clipped to what remains.
  function automatic logic [BL-1:0] burst_of(input logic [AW-1:0] a,
                                             input logic [LW-1:0] r);
    logic [LW:0] room;
    room = (LW+1)'(MAXB) - (LW+1)'(a[BSH +: MB]);
    if ({1'b0, r} < room) return BL'(r);
    else                  return BL'(room);
  endfunction

  assign go        = (state_q == IDLE) && start && (cfg_len != '0);
  assign zero_go   = (state_q == IDLE) && start && (cfg_len == '0);
  assign beat_in   = m_rdval && busy_c;
  assign last_beat = beat_in && ((beat_q + LW'(1)) == len_q);
  assign accept    = rval_c && m_rrdy;
  assign addr_nx   = addr_q + (AW'(rlen_q) << BSH);
  assign rem_nx    = rem_q - LW'(rlen_q);
  assign outst_sum = outst_q + OW'(rlen_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = REQ;
      REQ: begin
        if (last_beat)                      state_d = IDLE;
        else if (accept && rem_nx == '0)    state_d = DRAIN;
      end
      DRAIN:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a request stays valid once raised because outstanding can
  // only shrink until it is accepted.
  always_comb begin
    busy_c = (state_q != IDLE);
    rval_c = (state_q == REQ) && (outst_sum <= OW'(MO));
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      rlen_q   <= '0;
      outst_q  <= '0;
      done_q   <= 1'b0;
      o_val_q  <= 1'b0;
      o_data_q <= '0;
    end else begin
      done_q  <= last_beat || zero_go;
      o_val_q <= beat_in;
      if (beat_in) o_data_q <= m_rdata;
      if (go) begin
        addr_q  <= cfg_addr;
        rem_q   <= cfg_len;
        len_q   <= cfg_len;
        beat_q  <= '0;
        outst_q <= '0;
        rlen_q  <= burst_of(cfg_addr, cfg_len);
      end else if (busy_c) begin
        if (accept) begin
          addr_q <= addr_nx;
          rem_q  <= rem_nx;
          // Precompute the next burst so m_rlen is a plain register.
          rlen_q <= burst_of(addr_nx, rem_nx);
        end
        if (beat_in) beat_q <= beat_q + LW'(1);
        outst_q <= outst_q + (accept ? OW'(rlen_q) : OW'(0)) - OW'(beat_in);
      end
    end
  end

  assign busy    = busy_c;
  assign m_rval  = rval_c;
  assign m_rlen  = rlen_q;
  assign m_raddr = addr_q;
  assign done    = done_q;
  assign o_val   = o_val_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_xlib_avalon_dma_rd_ctrl.sv
module tb_xlib_avalon_dma_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, m_rval, o_val;
  logic        m_rrdy = 1'b1;
  logic        m_rdval = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  m_rlen;
  logic [31:0] m_raddr, o_data;

  typedef struct packed { logic [31:0] a; logic [3:0] l; } burst_t;
  typedef struct packed { logic [31:0] d; logic [31:0] t; } ret_t;

  burst_t      exp_b[$];
  logic [31:0] exp_d[$];
  bit          exp_done[$];
  ret_t        ret_q[$];

  int n_cmp = 0, n_err = 0;
  int acc_cnt = 0;
  logic [31:0] cyc = '0;
  bit hold = 1'b0;

  xlib_avalon_dma_rd_ctrl #(.DW(32), .AW(32), .BL(4), .LW(16), .MAXB(8), .MO(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .m_rrdy(m_rrdy), .m_rval(m_rval), .m_rlen(m_rlen),
    .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rdval(m_rdval), .o_data(o_data), .o_val(o_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor + bus model, sampling on the falling edge.
  always @(negedge clk) begin
    burst_t b;
    ret_t   r;
    logic [31:0] e;
    bit     ed;
    cyc <= cyc + 1;
    if (rst_n) begin
      if (m_rval && m_rrdy) begin
        acc_cnt++;
        if (exp_b.size() == 0) chk("burst_unexpected", 1, 0);
        else begin
          b = exp_b.pop_front();
          chk("burst_addr", m_raddr, b.a);
          chk("burst_len", m_rlen, b.l);
        end
        for (int k = 0; k < int'(m_rlen); k++) begin
          r.d = dat(m_raddr + 32'(4 * k));
          r.t = cyc + 2;
          ret_q.push_back(r);
        end
      end
      if (o_val) begin
        if (exp_d.size() == 0) chk("oval_unexpected", 1, 0);
        else begin
          e = exp_d.pop_front();
          chk("o_data", o_data, e);
        end
      end
      if (done) begin
        chk("done_busy", busy, 0);
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          ed = exp_done.pop_front();
          chk("done_with_oval", o_val, ed);
        end
      end
      if (!hold && ret_q.size() > 0 && ret_q[0].t <= cyc) begin
        r = ret_q.pop_front();
        m_rdval = 1'b1;
        m_rdata = r.d;
      end else begin
        m_rdval = 1'b0;
      end
    end else begin
      m_rdval = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [15:0] n);
    for (int i = 0; i < int'(n); i++) exp_d.push_back(dat(a + 32'(4 * i)));
    exp_done.push_back(n != 0);
    cfg_addr = a;
    cfg_len  = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] a, input logic [3:0] l);
    burst_t b;
    b.a = a;
    b.l = l;
    exp_b.push_back(b);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i = 0;
    while ((busy || exp_d.size() > 0 || exp_done.size() > 0) && i < budget) begin
      tick();
      i++;
    end
    chk(nm, (i >= budget) ? 1 : 0, 0);
    chk({nm, "_bursts_left"}, exp_b.size(), 0);
    repeat (3) tick();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rval"}, m_rval, 0);
    chk({nm, "_rlen"}, m_rlen, 0);
    chk({nm, "_raddr"}, m_raddr, 0);
    chk({nm, "_oval"}, o_val, 0);
    chk({nm, "_odata"}, o_data, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Aligned 16-word transfer: two full bursts.
    push_b(32'h00, 4'd8);
    push_b(32'h20, 4'd8);
    xfer(32'h0, 16'd16);
    chk("busy_after_start", busy, 1);
    wait_idle("t_aligned", 200);

    // Unaligned start at word 6: boundary split.
    push_b(32'h18, 4'd2);
    push_b(32'h20, 4'd3);
    xfer(32'h18, 16'd5);
    wait_idle("t_unaligned", 200);

    // Zero-length transfer.
    cfg_addr = 32'h40;
    cfg_len  = 16'd0;
    exp_done.push_back(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_rval", m_rval, 0);
    tick();
    chk("len0_done_clear", done, 0);
    chk("len0_busy2", busy, 0);
    chk("len0_rval2", m_rval, 0);
    wait_idle("t_len0", 20);

    // Outstanding limit: returns held off, only two bursts fit in MO.
    hold = 1'b1;
    acc_cnt = 0;
    push_b(32'h00, 4'd8);
    push_b(32'h20, 4'd8);
    push_b(32'h40, 4'd8);
    push_b(32'h60, 4'd8);
    xfer(32'h0, 16'd32);
    repeat (20) tick();
    chk("mo_accepts", acc_cnt, 2);
    chk("mo_rval_low", m_rval, 0);
    chk("mo_busy", busy, 1);
    hold = 1'b0;
    wait_idle("t_mo", 400);

    // Request stall: address/length held while m_rrdy is low; start ignored.
    m_rrdy = 1'b0;
    push_b(32'h10, 4'd4);
    push_b(32'h20, 4'd8);
    xfer(32'h10, 16'd12);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rval", m_rval, 1);
      chk("stall_raddr", m_raddr, 32'h10);
      chk("stall_rlen", m_rlen, 4);
      if (i == 1) begin
        cfg_addr = 32'h300;
        cfg_len  = 16'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start  = 1'b0;
    m_rrdy = 1'b1;
    wait_idle("t_stall", 200);

    // Reset in the middle of DRAIN abandons the transfer.
    hold = 1'b1;
    push_b(32'h40, 4'd8);
    push_b(32'h60, 4'd8);
    xfer(32'h40, 16'd16);
    repeat (10) tick();
    chk("drain_busy", busy, 1);
    chk("drain_rval", m_rval, 0);
    chk("drain_bursts_done", exp_b.size(), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    exp_d.delete();
    exp_done.delete();
    ret_q.delete();
    hold = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_idle", busy, 0);

    // Post-reset transfer that wraps the address space.
    push_b(32'hFFFF_FFF8, 4'd2);
    push_b(32'h0000_0000, 4'd2);
    xfer(32'hFFFF_FFF8, 16'd4);
    wait_idle("t_wrap", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
